// File: rtl/matvec_pkg.sv
// Shared types for the matrix-vector scheduler: fp32 word type and FSM states.
package matvec_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    ISSUE  = 3'd3,
    WAIT_Z = 3'd4,
    EMIT   = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/matvec_scheduler.sv
// matvec_scheduler: drives one shared inner_product unit row by row to form
// y = W*x. x is latched on start, each W row is read from a synchronous
// weight memory, issued as an operand pair, and the scalar result is handed
// downstream tagged with its row index.
// Optional feature: define MATVEC_PERF_EN to add the perf_cycles busy-cycle
// counter output.
module matvec_scheduler
  import matvec_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int AW = ($clog2(M) > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*FP_W-1:0] x,
  output logic              busy,
  output logic              done,
  output logic              w_rd,
  output logic [AW-1:0]     w_addr,
  input  logic [N*FP_W-1:0] w_data,
  output logic [N*FP_W-1:0] ip_a,
  output logic [N*FP_W-1:0] ip_b,
  output logic              ip_a_stb,
  output logic              ip_b_stb,
  input  logic              ip_a_ack,
  input  logic              ip_b_ack,
  input  fp32_t             ip_z,
  input  logic              ip_z_stb,
  output logic              ip_z_ack,
  output fp32_t             y,
  output logic [AW-1:0]     y_idx,
  output logic              y_stb,
  input  logic              y_ack
`ifdef MATVEC_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [N*FP_W-1:0] r_x;
  logic [N*FP_W-1:0] r_row_data;
  fp32_t             r_z;
  logic [AW-1:0]     r_row;
  logic              r_a_sent;
  logic              r_b_sent;

  logic              w_last;
  logic              w_a_xfer;
  logic              w_b_xfer;

  // Row bookkeeping and per-operand transfer detection in ISSUE
  assign w_last   = (r_row == AW'(M - 1));
  assign w_a_xfer = (r_state == ISSUE) && !r_a_sent && ip_a_ack;
  assign w_b_xfer = (r_state == ISSUE) && !r_b_sent && ip_b_ack;

  // Operands and results are passed straight from their holding registers
  assign ip_a   = r_x;
  assign ip_b   = r_row_data;
  assign y      = r_z;
  assign y_idx  = r_row;
  assign w_addr = (r_state == FETCH) ? r_row : '0;

  // State register; reset aborts any job in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and Moore outputs
  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    done     = 1'b0;
    w_rd     = 1'b0;
    ip_a_stb = 1'b0;
    ip_b_stb = 1'b0;
    ip_z_ack = 1'b0;
    y_stb    = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = FETCH;
      end
      FETCH: begin
        w_rd   = 1'b1;
        w_next = LOAD;
      end
      LOAD: w_next = ISSUE;
      ISSUE: begin
        // Each strobe falls on its own once its operand has been taken
        ip_a_stb = !r_a_sent;
        ip_b_stb = !r_b_sent;
        if ((r_a_sent || w_a_xfer) && (r_b_sent || w_b_xfer)) w_next = WAIT_Z;
      end
      WAIT_Z: begin
        ip_z_ack = 1'b1;
        if (ip_z_stb) w_next = EMIT;
      end
      EMIT: begin
        y_stb = 1'b1;
        if (y_ack) w_next = w_last ? DONE : FETCH;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Job data: latched x, current row, issue flags and captured result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x        <= '0;
      r_row_data <= '0;
      r_z        <= '0;
      r_row      <= '0;
      r_a_sent   <= 1'b0;
      r_b_sent   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= x;
            r_row <= '0;
          end
        end
        LOAD: begin
          r_row_data <= w_data;
          r_a_sent   <= 1'b0;
          r_b_sent   <= 1'b0;
        end
        ISSUE: begin
          if (w_a_xfer) r_a_sent <= 1'b1;
          if (w_b_xfer) r_b_sent <= 1'b1;
        end
        WAIT_Z: begin
          if (ip_z_stb) r_z <= ip_z;
        end
        EMIT: begin
          if (y_ack && !w_last) r_row <= r_row + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MATVEC_PERF_EN
  logic [31:0] r_perf;

  // Busy-cycle counter: cleared on accepted start, saturating, held after done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if (r_state == IDLE) begin
      if (start) r_perf <= '0;
    end else if (r_perf != 32'hFFFF_FFFF) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_matvec_scheduler.sv
// Bench for matvec_scheduler: an M=2 and an M=1 instance, each with a
// 1-cycle synchronous weight ROM and a behavioural fp32 inner-product peer
// whose operand-ack and result latencies are programmable.
module tb_matvec_scheduler;

  localparam int N  = 4;
  localparam int DW = N * 32;

  localparam logic [DW-1:0] XV   = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [DW-1:0] XALT = {32'h41000000, 32'h41000000, 32'h41000000, 32'h41000000};
  localparam logic [DW-1:0] W0   = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
  localparam logic [DW-1:0] W1   = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  localparam logic [31:0]   Y0   = 32'h428C0000;  // 70.0
  localparam logic [31:0]   Y1   = 32'h41200000;  // 10.0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start    [2];
  logic [DW-1:0] x        [2];
  logic          busy     [2];
  logic          done     [2];
  logic          w_rd     [2];
  logic [0:0]    w_addr   [2];
  logic [DW-1:0] w_data   [2];
  logic [DW-1:0] ip_a     [2];
  logic [DW-1:0] ip_b     [2];
  logic          ip_a_stb [2];
  logic          ip_b_stb [2];
  logic          ip_a_ack [2];
  logic          ip_b_ack [2];
  logic [31:0]   ip_z     [2];
  logic          ip_z_stb [2];
  logic          ip_z_ack [2];
  logic [31:0]   y        [2];
  logic [0:0]    y_idx    [2];
  logic          y_stb    [2];
  logic          y_ack    [2];
`ifdef MATVEC_PERF_EN
  logic [31:0]   perf     [2];
`endif

  matvec_scheduler #(.N(N), .M(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .x(x[0]), .busy(busy[0]), .done(done[0]),
    .w_rd(w_rd[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
    .ip_a(ip_a[0]), .ip_b(ip_b[0]), .ip_a_stb(ip_a_stb[0]), .ip_b_stb(ip_b_stb[0]),
    .ip_a_ack(ip_a_ack[0]), .ip_b_ack(ip_b_ack[0]),
    .ip_z(ip_z[0]), .ip_z_stb(ip_z_stb[0]), .ip_z_ack(ip_z_ack[0]),
    .y(y[0]), .y_idx(y_idx[0]), .y_stb(y_stb[0]), .y_ack(y_ack[0])
`ifdef MATVEC_PERF_EN
    , .perf_cycles(perf[0])
`endif
  );

  matvec_scheduler #(.N(N), .M(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .x(x[1]), .busy(busy[1]), .done(done[1]),
    .w_rd(w_rd[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
    .ip_a(ip_a[1]), .ip_b(ip_b[1]), .ip_a_stb(ip_a_stb[1]), .ip_b_stb(ip_b_stb[1]),
    .ip_a_ack(ip_a_ack[1]), .ip_b_ack(ip_b_ack[1]),
    .ip_z(ip_z[1]), .ip_z_stb(ip_z_stb[1]), .ip_z_ack(ip_z_ack[1]),
    .y(y[1]), .y_idx(y_idx[1]), .y_stb(y_stb[1]), .y_ack(y_ack[1])
`ifdef MATVEC_PERF_EN
    , .perf_cycles(perf[1])
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // fp32 <-> real helpers for the behavioural inner product
  function automatic real fp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2fp(input real v);
    logic        s;
    int          e;
    real         r;
    logic [22:0] m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    m = 23'($rtoi((r - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e), m};
  endfunction

  function automatic real dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    real acc = 0.0;
    for (int i = 0; i < N; i++) acc += fp2r(a[i*32 +: 32]) * fp2r(b[i*32 +: 32]);
    return acc;
  endfunction

  // Weight ROM, one-cycle read latency
  logic [DW-1:0] rom [2];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (w_rd[k]) w_data[k] <= rom[w_addr[k]];

  // Inner-product peer state
  int            a_dly, b_dly, z_lat;
  logic          a_done [2];
  logic          b_done [2];
  int            cnt_a  [2];
  int            cnt_b  [2];
  int            z_cnt  [2];
  logic [DW-1:0] a_op   [2];
  logic [DW-1:0] b_op   [2];
  int            a_xfers   [2];
  int            b_xfers   [2];
  int            extra_stb [2];

  // Inner-product peer: delayed operand acks, then a result after z_lat cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        ip_a_ack[k] <= 1'b0; ip_b_ack[k] <= 1'b0;
        ip_z_stb[k] <= 1'b0; ip_z[k]     <= '0;
        a_done[k]   <= 1'b0; b_done[k]   <= 1'b0;
        cnt_a[k]    <= 0;    cnt_b[k]    <= 0;    z_cnt[k] <= 0;
        a_op[k]     <= '0;   b_op[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ip_a_stb[k] && ip_a_ack[k]) begin
          a_op[k] <= ip_a[k]; a_done[k] <= 1'b1; ip_a_ack[k] <= 1'b0;
          a_xfers[k] <= a_xfers[k] + 1;
        end else if (ip_a_stb[k] && a_done[k]) begin
          extra_stb[k] <= extra_stb[k] + 1;
        end else if (ip_a_stb[k]) begin
          if (cnt_a[k] >= a_dly) ip_a_ack[k] <= 1'b1;
          else                   cnt_a[k] <= cnt_a[k] + 1;
        end
        if (ip_b_stb[k] && ip_b_ack[k]) begin
          b_op[k] <= ip_b[k]; b_done[k] <= 1'b1; ip_b_ack[k] <= 1'b0;
          b_xfers[k] <= b_xfers[k] + 1;
        end else if (ip_b_stb[k] && b_done[k]) begin
          extra_stb[k] <= extra_stb[k] + 1;
        end else if (ip_b_stb[k]) begin
          if (cnt_b[k] >= b_dly) ip_b_ack[k] <= 1'b1;
          else                   cnt_b[k] <= cnt_b[k] + 1;
        end
        if (a_done[k] && b_done[k] && !ip_z_stb[k]) begin
          if (z_cnt[k] >= z_lat) begin
            ip_z_stb[k] <= 1'b1;
            ip_z[k]     <= r2fp(dot(a_op[k], b_op[k]));
          end else begin
            z_cnt[k] <= z_cnt[k] + 1;
          end
        end
        if (ip_z_stb[k] && ip_z_ack[k]) begin
          ip_z_stb[k] <= 1'b0; a_done[k] <= 1'b0; b_done[k] <= 1'b0;
          cnt_a[k] <= 0; cnt_b[k] <= 0; z_cnt[k] <= 0;
        end
      end
    end
  end

  // Done-pulse counter
  int done_cnt [2];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (done[k]) done_cnt[k] <= done_cnt[k] + 1;

  // Split-issue observer: once one operand is taken its strobe must stay low
  int split_obs = 0;
  int split_err = 0;
  always @(negedge clk) begin
    if (rst && a_done[0] && !b_done[0]) begin
      split_obs <= split_obs + 1;
      if (ip_a_stb[0] !== 1'b0 || ip_b_stb[0] !== 1'b1) split_err <= split_err + 1;
    end
  end

  task automatic pulse_start(input int k, input logic [DW-1:0] xv);
    x[k]     = xv;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Wait for y, check value/index, hold off the ack for 'stall' cycles, then accept
  task automatic collect(input int k, input logic [31:0] ey, input logic [0:0] ei,
                         input int stall, input string tag);
    int t = 0;
    int unst = 0;
    while (y_stb[k] !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    chk({tag, "_ystb"}, DW'(y_stb[k]), DW'(1));
    chk({tag, "_y"},    DW'(y[k]),     DW'(ey));
    chk({tag, "_idx"},  DW'(y_idx[k]), DW'(ei));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (y_stb[k] !== 1'b1 || y[k] !== ey || y_idx[k] !== ei) unst++;
    end
    if (stall > 0) chk({tag, "_stable"}, DW'(unst), DW'(0));
    y_ack[k] = 1'b1;
    @(negedge clk);
    y_ack[k] = 1'b0;
    chk({tag, "_ydrop"}, DW'(y_stb[k]), DW'(0));
  endtask

  task automatic wait_done(input int k, input string tag);
    int t = 0;
    while (done[k] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_done"},      DW'(done[k]), DW'(1));
    chk({tag, "_busy_done"}, DW'(busy[k]), DW'(1));
    @(negedge clk);
    chk({tag, "_done_end"},  DW'(done[k]), DW'(0));
    chk({tag, "_idle"},      DW'(busy[k]), DW'(0));
  endtask

  task automatic run_job(input int stall, input string tag);
    int d0 = done_cnt[0];
    pulse_start(0, XV);
    chk({tag, "_busy"}, DW'(busy[0]), DW'(1));
    collect(0, Y0, 1'b0, stall, {tag, "_r0"});
    collect(0, Y1, 1'b1, stall, {tag, "_r1"});
    wait_done(0, tag);
    chk({tag, "_done_cnt"}, DW'(done_cnt[0] - d0), DW'(1));
  endtask

  initial begin
    int d0, ax0, bx0, ex0, so0, bc, got, t;
    logic dn, ack_sent;
    logic [31:0] yv;
    logic [0:0]  yi;

    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; x[k] = '0; y_ack[k] = 1'b0;
    end
    a_dly = 0; b_dly = 0; z_lat = 2;
    rom[0] = W0; rom[1] = W1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy",  DW'(busy[0]),     DW'(0));
    chk("rst_done",  DW'(done[0]),     DW'(0));
    chk("rst_wrd",   DW'(w_rd[0]),     DW'(0));
    chk("rst_astb",  DW'(ip_a_stb[0]), DW'(0));
    chk("rst_bstb",  DW'(ip_b_stb[0]), DW'(0));
    chk("rst_zack",  DW'(ip_z_ack[0]), DW'(0));
    chk("rst_ystb",  DW'(y_stb[0]),    DW'(0));
    chk("rst_y",     DW'(y[0]),        DW'(0));
    chk("rst_ipa",   ip_a[0],          DW'(0));
    chk("rst_ipb",   ip_b[0],          DW'(0));
    rst = 1'b1;
    @(negedge clk);

    // Basic job
    run_job(0, "s1");
    chk("s1_ipa_x", ip_a[0], XV);

    // Downstream back-pressure
    run_job(20, "s2");

    // Operand acks at different times
    a_dly = 0; b_dly = 3;
    ax0 = a_xfers[0]; bx0 = b_xfers[0]; ex0 = extra_stb[0]; so0 = split_obs;
    run_job(0, "s3");
    chk("s3_a_xfers", DW'(a_xfers[0] - ax0),  DW'(2));
    chk("s3_b_xfers", DW'(b_xfers[0] - bx0),  DW'(2));
    chk("s3_extra",   DW'(extra_stb[0] - ex0), DW'(0));
    chk("s3_split_seen", DW'(split_obs - so0 >= 4), DW'(1));
    chk("s3_split_err",  DW'(split_err), DW'(0));
    a_dly = 0; b_dly = 0;

    // start re-pulsed while busy is ignored
    d0 = done_cnt[0];
    pulse_start(0, XV);
    repeat (3) @(negedge clk);
    pulse_start(0, XALT);
    collect(0, Y0, 1'b0, 0, "s4_r0");
    chk("s4_ipa_x", ip_a[0], XV);
    collect(0, Y1, 1'b1, 0, "s4_r1");
    wait_done(0, "s4");
    chk("s4_done_cnt", DW'(done_cnt[0] - d0), DW'(1));
    x[0] = XV;

    // Reset during WAIT_Z of row 1
    pulse_start(0, XV);
    collect(0, Y0, 1'b0, 0, "s5_r0");
    z_lat = 10;
    t = 0;
    while (!(a_done[0] && b_done[0]) && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("s5_in_waitz", DW'(ip_z_ack[0]), DW'(1));
    d0  = done_cnt[0];
    rst = 1'b0;
    #1;
    chk("s5_busy",  DW'(busy[0]),     DW'(0));
    chk("s5_zack",  DW'(ip_z_ack[0]), DW'(0));
    chk("s5_ystb",  DW'(y_stb[0]),    DW'(0));
    chk("s5_y",     DW'(y[0]),        DW'(0));
    chk("s5_ipa",   ip_a[0],          DW'(0));
    @(negedge clk);
    chk("s5_still_idle", DW'(busy[0]), DW'(0));
    rst = 1'b1;
    z_lat = 2;
    repeat (2) @(negedge clk);
    chk("s5_no_done", DW'(done_cnt[0] - d0), DW'(0));
    run_job(0, "s5_after");

    // Single-row instance
    d0 = done_cnt[1];
    pulse_start(1, XV);
    bc = 0; got = 0; dn = 1'b0; ack_sent = 1'b0; yv = '0; yi = '0;
    for (int i = 0; i < 200 && !dn; i++) begin
      if (busy[1]) bc++;
      if (done[1]) dn = 1'b1;
      if (y_stb[1] && !ack_sent) begin
        yv = y[1]; yi = y_idx[1]; got++;
        y_ack[1] = 1'b1; ack_sent = 1'b1;
      end else begin
        y_ack[1] = 1'b0;
      end
      if (!dn) @(negedge clk);
    end
    chk("s6_done_seen", DW'(dn),  DW'(1));
    chk("s6_y_count",   DW'(got), DW'(1));
    chk("s6_y",         DW'(yv),  DW'(Y0));
    chk("s6_idx",       DW'(yi),  DW'(0));
    @(negedge clk);
    chk("s6_idle",      DW'(busy[1]), DW'(0));
    chk("s6_done_cnt",  DW'(done_cnt[1] - d0), DW'(1));
`ifdef MATVEC_PERF_EN
    chk("s6_perf",      DW'(perf[1]), DW'(bc));
    @(negedge clk);
    chk("s6_perf_hold", DW'(perf[1]), DW'(bc));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
